pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline control unit for the five-stage Y86-64 core. Sits beside the decode/writeback stage and the F/D/E/M/W pipeline registers, and generates every stall and bubble signal from stage icodes, register IDs, branch outcome, status codes and a data-memory wait handshake. A registered run-state machine sequences start-up, exception drain and halt. Optional performance counters are included.

## Interface
- Parameters: `CNT_W`, default 32, width of each performance counter.
- `clk_i` in 1: clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `start_i` in 1: one-cycle pulse; leaves IDLE.
- `D_icode_i` in 4: decode-stage icode.
- `d_srcA_i`, `d_srcB_i` in 4 each: decode source register IDs; 0xF = RNONE.
- `E_icode_i` in 4: execute-stage icode.
- `E_dstM_i` in 4: execute-stage memory destination register.
- `e_Cnd_i` in 1: branch-taken condition computed in execute.
- `M_icode_i` in 4: memory-stage icode.
- `m_stat_i` in 4: memory-stage status.
- `W_stat_i` in 4: writeback status.
- `dmem_busy_i` in 1: data memory not ready this cycle.
- `F_stall_o`, `D_stall_o`, `E_stall_o`, `M_stall_o`, `W_stall_o` out 1 each: hold the pipeline register.
- `D_bubble_o`, `E_bubble_o`, `M_bubble_o`, `W_bubble_o` out 1 each: load a nop into the pipeline register.
- `halted_o` out 1: state is HALT.
- `stat_o` out 4: latched terminal status.
- `cyc_cnt_o`, `lu_cnt_o`, `mp_cnt_o`, `ret_cnt_o` out CNT_W each: performance counters (see Configuration).

## Operation
- Encodings:
  - Icodes: IMRMOVQ=5, IJXX=7, IRET=9, IPOPQ=0xB.
  - Status: SAOK=1, SHLT=2, SADR=3, SINS=4. "exc(x)" means x != SAOK.
- Hazard terms, all combinational:
  - lu = E_icode in {5, 0xB} && E_dstM != 0xF && E_dstM in {d_srcA, d_srcB}.
  - ret = IRET in {D_icode, E_icode, M_icode}.
  - mp = E_icode == IJXX && !e_Cnd.
- States: IDLE (reset), RUN, DRAIN, HALT. Transitions:
  - IDLE → RUN on start_i.
  - RUN → DRAIN when exc(m_stat_i) && !dmem_busy_i.
  - DRAIN → HALT when exc(W_stat_i). Also RUN → HALT directly if exc(W_stat_i).
  - HALT is terminal until rst_i.
- Outputs in RUN or DRAIN with dmem_busy_i = 0:
  - F_stall = lu | ret.
  - D_stall = lu.
  - D_bubble = mp | (ret & !lu).
  - E_bubble = mp | lu.
  - M_bubble = exc(m_stat) | exc(W_stat).
  - W_stall = exc(W_stat).
  - E_stall, M_stall and W_bubble = 0.
- Outputs in RUN or DRAIN with dmem_busy_i = 1:
  - F, D, E, M stall asserted; W_bubble = 1.
  - All other bubbles = 0. Busy overrides every hazard term.
- Outputs in IDLE and HALT:
  - F_stall = D_stall = W_stall = 1.
  - E_bubble = M_bubble = 1.
  - All other outputs 0.
- stat_o: loaded with W_stat_i on the cycle DRAIN/RUN → HALT; holds afterwards.

## Timing
- All control outputs are combinational from the registered state and the current inputs, so they are valid in the same cycle as their causes.
- State, stat_o and the counters update on posedge clk_i.
- Reset values:
  - State = IDLE, halted_o = 0, stat_o = SAOK (1), all counters 0.
  - Control outputs take their IDLE values: F/D/W stall = 1, E/M bubble = 1, rest 0.
- start_i is ignored outside IDLE.
- lu and ret together: D_stall = 1 and D_bubble = 0 (stall wins). F_stall = 1.
- mp and ret together: D_bubble = 1 and F_stall = 1.
- exc(m_stat) while dmem_busy: no transition. The memory result is not final, so the state stays RUN.
- halted_o rises the cycle after the W-stage exception is seen.
- rst_i mid-operation: asynchronously returns to IDLE and clears all registers.

## Configuration
- `PIPE_CTRL_PERF_EN`:
  - Defined: counters are live. Each increments once per cycle in RUN/DRAIN:
    - cyc_cnt_o every such cycle.
    - lu_cnt_o when lu && !busy.
    - mp_cnt_o when mp && !busy.
    - ret_cnt_o when ret && !lu && !busy.
  - Counters wrap modulo 2^CNT_W and freeze in IDLE/HALT.
  - Undefined: counter registers are not built and all four outputs are tied to 0.

## Test plan
- Reset, then hold 3 cycles without start_i: F_stall = 1, E_bubble = 1, halted_o = 0, stat_o = 1. Pulse start_i: next cycle all outputs 0 with idle inputs.
- E_icode = 5, E_dstM = 3, d_srcB = 3: F_stall = D_stall = E_bubble = 1, D_bubble = 0. With E_dstM = 0xF, all outputs 0.
- E_icode = 7, e_Cnd = 0: D_bubble = E_bubble = 1, F_stall = 0. Same with e_Cnd = 1: all 0.
- D_icode = 9: F_stall = D_bubble = 1. Add lu at the same time: D_stall = 1, D_bubble = 0.
- Drive m_stat = 3 with dmem_busy = 1 for 2 cycles: F/D/E/M stall and W_bubble asserted, state stays RUN. Drop busy: M_bubble = 1, next state DRAIN. Then W_stat = 3: W_stall = 1, next cycle halted_o = 1, stat_o = 3.
- With `PIPE_CTRL_PERF_EN` and CNT_W = 4: run 17 cycles in RUN and check cyc_cnt_o = 1 (wrap). Assert rst_i mid-run: counters 0 and state IDLE immediately.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: stall/bubble generation plus IDLE/RUN/DRAIN/HALT run-state machine.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined; otherwise they read 0.
module pipe_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       D_icode_i,
  input  logic [3:0]       d_srcA_i,
  input  logic [3:0]       d_srcB_i,
  input  logic [3:0]       E_icode_i,
  input  logic [3:0]       E_dstM_i,
  input  logic             e_Cnd_i,
  input  logic [3:0]       M_icode_i,
  input  logic [3:0]       m_stat_i,
  input  logic [3:0]       W_stat_i,
  input  logic             dmem_busy_i,
  output logic             F_stall_o,
  output logic             D_stall_o,
  output logic             E_stall_o,
  output logic             M_stall_o,
  output logic             W_stall_o,
  output logic             D_bubble_o,
  output logic             E_bubble_o,
  output logic             M_bubble_o,
  output logic             W_bubble_o,
  output logic             halted_o,
  output logic [3:0]       stat_o,
  output logic [CNT_W-1:0] cyc_cnt_o,
  output logic [CNT_W-1:0] lu_cnt_o,
  output logic [CNT_W-1:0] mp_cnt_o,
  output logic [CNT_W-1:0] ret_cnt_o
);

  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [3:0] SAOK    = 4'h1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_stat;
  logic       w_load_stat;

  logic       w_lu;
  logic       w_ret;
  logic       w_mp;
  logic       w_m_exc;
  logic       w_w_exc;
  logic       w_active;

  assign w_lu = ((E_icode_i == IMRMOVQ) || (E_icode_i == IPOPQ)) &&
                (E_dstM_i != RNONE) &&
                ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
  assign w_ret    = (D_icode_i == IRET) || (E_icode_i == IRET) || (M_icode_i == IRET);
  assign w_mp     = (E_icode_i == IJXX) && !e_Cnd_i;
  assign w_m_exc  = (m_stat_i != SAOK);
  assign w_w_exc  = (W_stat_i != SAOK);
  assign w_active = (r_state == S_RUN) || (r_state == S_DRAIN);

  // A memory-stage exception is only trusted once the data memory has finished.
  always_comb begin
    w_state_next = r_state;
    w_load_stat  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) w_state_next = S_RUN;
      end
      S_RUN: begin
        if (w_w_exc) begin
          w_state_next = S_HALT;
          w_load_stat  = 1'b1;
        end else if (w_m_exc && !dmem_busy_i) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_w_exc) begin
          w_state_next = S_HALT;
          w_load_stat  = 1'b1;
        end
      end
      S_HALT: begin
        w_state_next = S_HALT;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    F_stall_o  = 1'b0;
    D_stall_o  = 1'b0;
    E_stall_o  = 1'b0;
    M_stall_o  = 1'b0;
    W_stall_o  = 1'b0;
    D_bubble_o = 1'b0;
    E_bubble_o = 1'b0;
    M_bubble_o = 1'b0;
    W_bubble_o = 1'b0;
    if (!w_active) begin
      F_stall_o  = 1'b1;
      D_stall_o  = 1'b1;
      W_stall_o  = 1'b1;
      E_bubble_o = 1'b1;
      M_bubble_o = 1'b1;
    end else if (dmem_busy_i) begin
      // Freeze everything upstream of memory; feed writeback nops meanwhile.
      F_stall_o  = 1'b1;
      D_stall_o  = 1'b1;
      E_stall_o  = 1'b1;
      M_stall_o  = 1'b1;
      W_bubble_o = 1'b1;
    end else begin
      F_stall_o  = w_lu | w_ret;
      D_stall_o  = w_lu;
      D_bubble_o = w_mp | (w_ret & !w_lu);
      E_bubble_o = w_mp | w_lu;
      M_bubble_o = w_m_exc | w_w_exc;
      W_stall_o  = w_w_exc;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_stat  <= SAOK;
    end else begin
      r_state <= w_state_next;
      if (w_load_stat) r_stat <= W_stat_i;
    end
  end

  assign halted_o = (r_state == S_HALT);
  assign stat_o   = r_stat;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] r_cyc_cnt;
  logic [CNT_W-1:0] r_lu_cnt;
  logic [CNT_W-1:0] r_mp_cnt;
  logic [CNT_W-1:0] r_ret_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cyc_cnt <= '0;
      r_lu_cnt  <= '0;
      r_mp_cnt  <= '0;
      r_ret_cnt <= '0;
    end else if (w_active) begin
      r_cyc_cnt <= r_cyc_cnt + 1'b1;
      if (w_lu && !dmem_busy_i)           r_lu_cnt  <= r_lu_cnt + 1'b1;
      if (w_mp && !dmem_busy_i)           r_mp_cnt  <= r_mp_cnt + 1'b1;
      if (w_ret && !w_lu && !dmem_busy_i) r_ret_cnt <= r_ret_cnt + 1'b1;
    end
  end

  assign cyc_cnt_o = r_cyc_cnt;
  assign lu_cnt_o  = r_lu_cnt;
  assign mp_cnt_o  = r_mp_cnt;
  assign ret_cnt_o = r_ret_cnt;
`else
  assign cyc_cnt_o = '0;
  assign lu_cnt_o  = '0;
  assign mp_cnt_o  = '0;
  assign ret_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized self-checking bench for pipe_ctrl against a rule-level reference model.
// Counter checks follow PIPE_CTRL_PERF_EN: live counts when defined, constant zero otherwise.
module tb_pipe_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [3:0]    D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, m_stat, W_stat;
  logic          e_Cnd, busy;
  logic          F_stall, D_stall, E_stall, M_stall, W_stall;
  logic          D_bubble, E_bubble, M_bubble, W_bubble;
  logic          halted;
  logic [3:0]    stat;
  logic [CW-1:0] cyc_cnt, lu_cnt, mp_cnt, ret_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model state: run phase as a name-level integer, plus plain counts.
  localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_HALT = 3;
  int         m_phase;
  logic [3:0] m_stat_l;
  int         n_cyc, n_lu, n_mp, n_ret;

  always #5 clk = ~clk;

  pipe_ctrl #(.CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .D_icode_i(D_icode), .d_srcA_i(d_srcA), .d_srcB_i(d_srcB),
    .E_icode_i(E_icode), .E_dstM_i(E_dstM), .e_Cnd_i(e_Cnd),
    .M_icode_i(M_icode), .m_stat_i(m_stat), .W_stat_i(W_stat),
    .dmem_busy_i(busy),
    .F_stall_o(F_stall), .D_stall_o(D_stall), .E_stall_o(E_stall),
    .M_stall_o(M_stall), .W_stall_o(W_stall),
    .D_bubble_o(D_bubble), .E_bubble_o(E_bubble), .M_bubble_o(M_bubble),
    .W_bubble_o(W_bubble), .halted_o(halted), .stat_o(stat),
    .cyc_cnt_o(cyc_cnt), .lu_cnt_o(lu_cnt), .mp_cnt_o(mp_cnt), .ret_cnt_o(ret_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_lu();
    return ((E_icode == 4'h5) || (E_icode == 4'hB)) && (E_dstM != 4'hF) &&
           ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  endfunction

  function automatic bit is_ret();
    return (D_icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
  endfunction

  function automatic bit is_mp();
    return (E_icode == 4'h7) && !e_Cnd;
  endfunction

  // Bit order: F D E M W stall, then D E M W bubble.
  function automatic logic [8:0] exp_ctrl();
    bit lu, rt, mp, me, we;
    lu = is_lu(); rt = is_ret(); mp = is_mp();
    me = (m_stat != 4'h1); we = (W_stat != 4'h1);
    if (m_phase == P_IDLE || m_phase == P_HALT) return 9'b11001_0110;
    if (busy) return 9'b11110_0001;
    return {lu | rt, lu, 1'b0, 1'b0, we, mp | (rt & !lu), mp | lu, me | we, 1'b0};
  endfunction

  function automatic logic [15:0] exp_cnts();
`ifdef PIPE_CTRL_PERF_EN
    return {4'(n_cyc % 16), 4'(n_lu % 16), 4'(n_mp % 16), 4'(n_ret % 16)};
`else
    return 16'h0;
`endif
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_stat_l = 4'h1;
    n_cyc = 0; n_lu = 0; n_mp = 0; n_ret = 0;
  endtask

  task automatic model_clock();
    bit running;
    running = (m_phase == P_RUN) || (m_phase == P_DRAIN);
    if (running) begin
      n_cyc++;
      if (is_lu() && !busy) n_lu++;
      if (is_mp() && !busy) n_mp++;
      if (is_ret() && !is_lu() && !busy) n_ret++;
    end
    case (m_phase)
      P_IDLE: if (start) m_phase = P_RUN;
      P_RUN: begin
        if (W_stat != 4'h1) begin m_phase = P_HALT; m_stat_l = W_stat; end
        else if (m_stat != 4'h1 && !busy) m_phase = P_DRAIN;
      end
      P_DRAIN: if (W_stat != 4'h1) begin m_phase = P_HALT; m_stat_l = W_stat; end
      default: ;
    endcase
  endtask

  task automatic idle_inputs();
    start = 0; D_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF;
    E_icode = 4'h1; E_dstM = 4'hF; e_Cnd = 0; M_icode = 4'h1;
    m_stat = 4'h1; W_stat = 4'h1; busy = 0;
  endtask

  // Called just after a falling edge with inputs applied; checks, then clocks once.
  task automatic step(input string tag);
    #1;
    check({tag, ":ctrl"}, {F_stall, D_stall, E_stall, M_stall, W_stall,
                           D_bubble, E_bubble, M_bubble, W_bubble}, exp_ctrl());
    check({tag, ":halted"}, halted, (m_phase == P_HALT));
    check({tag, ":stat"}, stat, m_stat_l);
    check({tag, ":cnt"}, {cyc_cnt, lu_cnt, mp_cnt, ret_cnt}, exp_cnts());
    $display("step %-10s ph=%0d D=%h E=%h M=%h busy=%b m=%h W=%h ctrl=%b halt=%b",
             tag, m_phase, D_icode, E_icode, M_icode, busy, m_stat, W_stat,
             {F_stall, D_stall, E_stall, M_stall, W_stall, D_bubble, E_bubble, M_bubble, W_bubble},
             halted);
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst = 1;
    model_reset();
    #1;
    check("rst:async_ctrl", {F_stall, E_bubble, halted}, 3'b110);
    check("rst:async_cnt", {cyc_cnt, lu_cnt, mp_cnt, ret_cnt}, 16'h0);
    @(negedge clk);
    rst = 0;
  endtask

  function automatic logic [3:0] rand_icode();
    logic [3:0] tbl [6] = '{4'h1, 4'h5, 4'h7, 4'h9, 4'hB, 4'h6};
    return tbl[$urandom_range(0, 5)];
  endfunction

  function automatic logic [3:0] rand_reg();
    return ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 3));
  endfunction

  function automatic logic [3:0] rand_stat(input int pct);
    return ($urandom_range(0, 99) < pct) ? 4'($urandom_range(2, 4)) : 4'h1;
  endfunction

  initial begin
    idle_inputs();
    rst = 1;
    model_reset();
    #1;
    check("reset:stat", stat, 4'h1);
    check("reset:halted", halted, 1'b0);
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < 3; i++) step("idle");
    start = 1; step("start");
    start = 0; step("run_idle");
    check("run:all_zero", {F_stall, D_stall, E_stall, M_stall, W_stall,
                            D_bubble, E_bubble, M_bubble, W_bubble}, 9'h0);

    E_icode = 4'h5; E_dstM = 4'h3; d_srcB = 4'h3; step("loaduse");
    E_dstM = 4'hF; step("lu_rnone");
    idle_inputs(); E_icode = 4'h7; e_Cnd = 0; step("mispred");
    e_Cnd = 1; step("taken");
    idle_inputs(); D_icode = 4'h9; step("ret");
    E_icode = 4'hB; E_dstM = 4'h2; d_srcA = 4'h2; step("ret_lu");
    E_icode = 4'h7; e_Cnd = 0; E_dstM = 4'hF; step("ret_mp");
    start = 1; idle_inputs(); start = 1; step("start_ign");
    start = 0;

    m_stat = 4'h3; busy = 1; step("busy1"); step("busy2");
    busy = 0; step("m_exc");
    m_stat = 4'h1; W_stat = 4'h3; step("w_exc");
    W_stat = 4'h1; step("halted");
    check("halt:flag", halted, 1'b1);
    check("halt:stat", stat, 4'h3);
    start = 1; step("halt_start");
    start = 0;

`ifdef PIPE_CTRL_PERF_EN
    do_reset();
    idle_inputs(); start = 1; step("cnt_start");
    start = 0;
    for (int i = 0; i < 17; i++) step("cnt_run");
    #1 check("cnt:wrap", cyc_cnt, 4'h1);
    @(negedge clk);
`endif

    for (int s = 0; s < 3; s++) begin
      do_reset();
      idle_inputs(); start = 1; step("rnd_start");
      for (int c = 0; c < 200; c++) begin
        start   = ($urandom_range(0, 19) == 0);
        D_icode = rand_icode(); E_icode = rand_icode(); M_icode = rand_icode();
        d_srcA  = rand_reg(); d_srcB = rand_reg(); E_dstM = rand_reg();
        e_Cnd   = 1'($urandom_range(0, 1));
        busy    = ($urandom_range(0, 4) == 0);
        m_stat  = rand_stat(5);
        W_stat  = rand_stat(2);
        step("rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
